// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial sequence detector.
// Holds the reset-time pattern defaults and the pattern-length clamp.
package seq_det_pkg;

    localparam logic [7:0] DEF_PAT = 8'b0000_0001;
    localparam int         DEF_LEN = 3;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } fill_state_e;

    // A zero length still means "one bit"; anything longer than the shift register is cut down
    function automatic int clamp_len(input int pat_len, input int max_w);
        if (pat_len <= 0) begin
            return 1;
        end else if (pat_len > max_w) begin
            return max_w;
        end else begin
            return pat_len;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter. A clear wins over an increment in the same cycle;
// once at all-ones the count holds instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {CNT_W{1'b1}})) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_det_param.sv
// Programmable serial sequence detector: runtime pattern/length, overlap mode,
// input enable and a saturating match counter.
//
// state   | meaning
// S_FILL  | fewer than len valid bits collected since reset/load/restart
// S_ARMED | len valid bits held; every enabled bit is a match candidate
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               MAX_W   = 8,
    parameter int               LEN_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [MAX_W-1:0] DEF_PAT = MAX_W'(seq_det_pkg::DEF_PAT),
    parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(seq_det_pkg::DEF_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             pat_load,
    input  logic [MAX_W-1:0] pat_in,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    // The oldest history bit is never compared, so only MAX_W-1 past bits are stored.
    logic [MAX_W-2:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [MAX_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_y;

    logic [MAX_W-1:0] w_hist_n;
    logic [MAX_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_n;
    logic [LEN_W-1:0] w_len_cl;
    fill_state_e      w_state;
    logic             w_match;

    assign w_state  = (r_fill == r_len) ? S_ARMED : S_FILL;
    assign w_hist_n = {r_hist, x};
    assign w_fill_n = (w_state == S_ARMED) ? r_len : (r_fill + 1'b1);
    assign w_mask   = ~({MAX_W{1'b1}} << r_len);
    assign w_len_cl = LEN_W'(clamp_len(int'(pat_len), MAX_W));

    assign w_match = en && !pat_load && (w_fill_n == r_len)
                     && (((w_hist_n ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEF_PAT;
            r_len  <= DEF_LEN;
            r_y    <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_len  <= w_len_cl;
            r_hist <= '0;
            r_fill <= '0;
            r_y    <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n[MAX_W-2:0];
            r_y    <= w_match;
            r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
        end else begin
            r_y    <= 1'b0;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (w_match),
        .q     (match_cnt)
    );

    assign y = r_y;

endmodule

// File: tb/tb_seq_det_param.sv
// Bench for seq_det_param: directed scenarios then random traffic, two instances
// (8-bit and 2-bit counters) sharing stimulus, checked against a bit-queue model.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       reset, en, x, pat_load, overlap, cnt_clr;
    logic [7:0] pat_in;
    logic [3:0] pat_len;
    logic       y, y2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit         m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    logic       m_y;
    int         m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    seq_det_param #(.MAX_W(8), .LEN_W(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
        .pat_in(pat_in), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y), .match_cnt(match_cnt)
    );

    seq_det_param #(.MAX_W(8), .LEN_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .x(x), .pat_load(pat_load),
        .pat_in(pat_in), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
        .y(y2), .match_cnt(match_cnt2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    function automatic int len_of(input logic [3:0] pl);
        if (pl == 0) return 1;
        if (pl > 8) return 8;
        return int'(pl);
    endfunction

    task automatic model(input logic e, input logic xi, input logic ld,
                         input logic [7:0] pin, input logic [3:0] pl,
                         input logic ov, input logic cl, input logic rs);
        bit hit;
        hit = 1'b0;
        if (rs) begin
            m_q.delete();
            m_pat = 8'b001; m_len = 3; m_y = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (ld) begin
            m_pat = pin; m_len = len_of(pl); m_q.delete();
        end else if (e) begin
            m_q.push_back(xi);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (m_q.size() >= m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (m_q[m_q.size()-1-i] != m_pat[i]) hit = 1'b0;
            end
            if (hit && !ov) m_q.delete();
        end
        m_y = hit;
        if (cl) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (hit) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic step(input logic e, input logic xi, input logic ld,
                        input logic [7:0] pin, input logic [3:0] pl,
                        input logic ov, input logic cl, input logic rs);
        @(negedge clk);
        reset = rs; en = e; x = xi; pat_load = ld; pat_in = pin;
        pat_len = pl; overlap = ov; cnt_clr = cl;
        @(posedge clk);
        model(e, xi, ld, pin, pl, ov, cl, rs);
        #1;
        chk("y", int'(y), int'(m_y));
        chk("y2", int'(y2), int'(m_y));
        chk("cnt8", int'(match_cnt), m_cnt8);
        chk("cnt2", int'(match_cnt2), m_cnt2);
    endtask

    task automatic bit_in(input logic xi, input logic ov);
        step(1'b1, xi, 1'b0, 8'h00, 4'd0, ov, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [7:0] pin, input logic [3:0] pl, input logic ov);
        step(1'b0, 1'b0, 1'b1, pin, pl, ov, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] pin;
        logic [3:0] pl;
        logic ov, e, ld, cl, rs;
        m_pat = 8'b001; m_len = 3; m_y = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        reset = 1'b1; en = 1'b0; x = 1'b0; pat_load = 1'b0; pat_in = '0;
        pat_len = '0; overlap = 1'b1; cnt_clr = 1'b0;

        // 1: default pattern 001
        do_reset();
        chk("t1_rst_y", int'(y), 0);
        chk("t1_rst_cnt", int'(match_cnt), 0);
        bit_in(0, 1); bit_in(0, 1);
        chk("t1_pre_y", int'(y), 0);
        bit_in(1, 1);
        chk("t1_y", int'(y), 1);
        chk("t1_cnt", int'(match_cnt), 1);
        bit_in(0, 1);
        chk("t1_pulse_w", int'(y), 0);

        // 2: 0101 overlapping, then non-overlapping
        load(8'b0101, 4'd4, 1);
        for (int i = 0; i < 6; i++) bit_in(i[0], 1);
        chk("t2_ovl_cnt", int'(match_cnt), 2);
        load(8'b0101, 4'd4, 0);
        for (int i = 0; i < 6; i++) bit_in(i[0], 0);
        chk("t2_novl_cnt", int'(match_cnt), 1);

        // 3: enable gating
        load(8'b001, 4'd3, 1);
        bit_in(0, 1); bit_in(0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0);
            chk("t3_dis_y", int'(y), 0);
        end
        bit_in(1, 1);
        chk("t3_y", int'(y), 1);
        chk("t3_cnt", int'(match_cnt), 1);

        // 4: reload mid-stream discards history
        load(8'b001, 4'd3, 1);
        bit_in(0, 1); bit_in(0, 1);
        step(1'b1, 1'b1, 1'b1, 8'b11, 4'd2, 1'b1, 1'b0, 1'b0);
        chk("t4_load_y", int'(y), 0);
        bit_in(1, 1);
        chk("t4_first_y", int'(y), 0);
        bit_in(1, 1);
        chk("t4_second_y", int'(y), 1);

        // 5: length-1 pattern, saturation, clear priority, length clamp
        load(8'b1, 4'd1, 1);
        for (int i = 0; i < 5; i++) begin
            bit_in(1, 1);
            chk("t5_sat", int'(match_cnt2), (i < 3) ? i + 1 : 3);
        end
        step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0);
        chk("t5_clr_y", int'(y), 1);
        chk("t5_clr", int'(match_cnt2), 0);
        load(8'b1, 4'd0, 1);
        bit_in(1, 1);
        chk("t5_len0", int'(y), 1);
        load(8'hFF, 4'd15, 1);
        for (int i = 0; i < 8; i++) begin
            bit_in(1, 1);
            chk("t5_len15", int'(y), (i == 7) ? 1 : 0);
        end

        // 6: reset mid-stream
        do_reset();
        bit_in(0, 1); bit_in(0, 1);
        do_reset();
        chk("t6_rst_y", int'(y), 0);
        chk("t6_rst_cnt", int'(match_cnt), 0);
        bit_in(1, 1);
        chk("t6_y", int'(y), 0);

        // random traffic
        ov = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom % 500) == 0;
            ld = ($urandom % 40) == 0;
            cl = ($urandom % 100) == 0;
            e  = ($urandom % 5) != 0;
            if (($urandom % 50) == 0) ov = ~ov;
            pin = 8'($urandom);
            pl  = (($urandom % 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
            step(e, 1'($urandom), ld, pin, pl, ov, cl, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
